i2s_rcvr_ctrl: RTL and testbench
================================

I2S_RCVR_CTRL -- requirements
Module: i2s_rcvr_ctrl

Purpose: upstream control stage of the I2S receiver. Synchronizes the external I2S lines, drives the 16-bit serial-to-parallel shift register (shift/data_in), reads back its parallel word, and presents stereo sample pairs.

Interface
REQ-001 SHALL have parameter WORD_BITS, default 16, meaning bits per channel word; the design is only required to support 16.
REQ-002 clk  input  1  system clock; one clock only, all logic on rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 sck  input  1  I2S bit clock, asynchronous to clk; f(clk) >= 8 x f(sck).
REQ-005 ws  input  1  I2S word select, asynchronous; 0 = left, 1 = right.
REQ-006 sd  input  1  I2S serial data, asynchronous, MSB first.
REQ-007 sr_data  input  16  parallel output of the downstream shift register.
REQ-008 shift  output  1  one-cycle shift enable to the shift register.
REQ-009 data_in  output  1  serial bit to the shift register, qualified by shift.
REQ-010 left_sample  output  16  last captured left word, held between updates.
REQ-011 right_sample  output  16  last captured right word, held between updates.
REQ-012 sample_valid  output  1  one-cycle pulse: a new left/right pair is on the sample outputs.
REQ-013 sync_err  output  1  one-cycle pulse: a word was cut short by a ws change.

Function
REQ-014 sck, ws and sd SHALL each pass through a 2-flop synchronizer; a third sck flop SHALL give edge detection.
REQ-015 tick SHALL be asserted for exactly one clk cycle per sck rising edge, 3 clk cycles after the edge at the pins (+/-1).
REQ-016 On each tick, synchronized ws and sd SHALL be sampled; ws_last SHALL be updated with the sampled ws; a ws change is defined as sampled ws != ws_last.
REQ-017 shift SHALL be asserted only in the tick cycle, with data_in equal to the sampled sd in the same cycle; shift SHALL be 0 in all other cycles.
REQ-018 FSM states: IDLE, ARM, SHIFT, CAPTURE, WAIT.
REQ-019 IDLE: first tick loads ws_last only -> ARM.
REQ-020 ARM: tick with ws change -> SHIFT, cur_ch = sampled ws, bit_cnt = 0; the bit at that tick is not shifted.
REQ-021 SHIFT: each tick asserts shift and increments bit_cnt; when bit_cnt reaches 16 -> CAPTURE. If the ws change that starts the next word coincides with the 16th tick, that bit is still the old word's LSB, and pend_start SHALL be set.
REQ-022 SHIFT, tick with ws change while bit_cnt after increment < 16: the bit SHALL be shifted but discarded; sync_err SHALL pulse next cycle; bit_cnt = 0; cur_ch = sampled ws; remain in SHIFT; no capture.
REQ-023 CAPTURE (one cycle): sr_data SHALL be latched into left_sample if cur_ch = 0, else into right_sample.
REQ-024 CAPTURE exit: if pend_start = 1 -> SHIFT with bit_cnt = 0, cur_ch = ~cur_ch, pend_start cleared; otherwise -> WAIT.
REQ-025 WAIT: ticks are ignored (shift = 0) until a tick with ws change -> SHIFT, bit_cnt = 0, cur_ch = sampled ws. This supports channel frames longer than 16 sck.
REQ-026 left_fresh SHALL be set on a left capture. It SHALL be cleared when sample_valid pulses.
REQ-027 sample_valid SHALL pulse in the cycle after a right capture if left_fresh = 1; a right capture with left_fresh = 0 SHALL update right_sample without a pulse.
REQ-028 Ticks SHALL be guaranteed (by the REQ-004 ratio) never to coincide with CAPTURE; behaviour for slower clk is undefined.

Reset
REQ-029 When n_rst = 0, the block SHALL immediately set state = IDLE, all synchronizer flops, ws_last, cur_ch, bit_cnt, pend_start and left_fresh to 0, and shift, data_in, left_sample, right_sample, sample_valid and sync_err to 0.
REQ-030 Reset asserted mid-word SHALL discard the partial word; after release the block SHALL realign through IDLE/ARM before producing any sample_valid.

Verification
REQ-031 Standard I2S, 16 sck per channel, left = 0xA5C3, right = 0x1234 -> after one ws realignment, sample_valid pulses once per frame; left_sample = 0xA5C3, right_sample = 0x1234.
REQ-032 32 sck per channel, MSB-aligned words 0x8001 / 0x7FFE, trailing bits random -> extra bits are ignored (WAIT), samples are exact, sync_err = 0.
REQ-033 ws toggles after 10 bits of the left word -> sync_err pulses once, left_sample is unchanged, and no sample_valid occurs for that frame.
REQ-034 Count shift pulses over 5 frames of 16+16 -> exactly 160 pulses, each one cycle wide, each with data_in equal to the driven sd bit.
REQ-035 n_rst pulsed low mid right word -> all outputs are 0 asynchronously; the first sample_valid after release follows a full realignment plus a complete left+right pair.
REQ-036 Stream starts with ws = 1 (right first) -> the first right capture gives no sample_valid; the first pulse follows the next left+right pair.

Source files
------------

// File: rtl/i2s_rcvr_ctrl.sv
// I2S receiver control: synchronizes sck/ws/sd, steers an external serial-to-parallel
// shift register and assembles left/right sample pairs from its parallel word.
module i2s_rcvr_ctrl #(
  parameter int WORD_BITS = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 sck,
  input  logic                 ws,
  input  logic                 sd,
  input  logic [WORD_BITS-1:0] sr_data,
  output logic                 shift,
  output logic                 data_in,
  output logic [WORD_BITS-1:0] left_sample,
  output logic [WORD_BITS-1:0] right_sample,
  output logic                 sample_valid,
  output logic                 sync_err
);

  localparam int CNT_W = $clog2(WORD_BITS + 1);
  localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_BITS);

  typedef enum logic [2:0] {IDLE, ARM, SHIFT, CAPTURE, WAIT} state_t;

  state_t           state;
  logic             sck_s1, sck_s2, sck_s3;
  logic             ws_s1, ws_s2;
  logic             sd_s1, sd_s2;
  logic             ws_last, cur_ch, pend_start, left_fresh;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_cnt_inc;
  logic             tick, ws_chg;

  // synchronizer stage: two flops per line, third sck flop for edge detection
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sck_s1 <= 1'b0;
      sck_s2 <= 1'b0;
      sck_s3 <= 1'b0;
      ws_s1  <= 1'b0;
      ws_s2  <= 1'b0;
      sd_s1  <= 1'b0;
      sd_s2  <= 1'b0;
    end else begin
      sck_s1 <= sck;
      sck_s2 <= sck_s1;
      sck_s3 <= sck_s2;
      ws_s1  <= ws;
      ws_s2  <= ws_s1;
      sd_s1  <= sd;
      sd_s2  <= sd_s1;
    end
  end

  assign tick        = sck_s2 & ~sck_s3;
  assign ws_chg      = ws_s2 ^ ws_last;
  assign bit_cnt_inc = bit_cnt + 1'b1;

  // Shift must land in the tick cycle itself so the register holds the full word by CAPTURE.
  assign shift   = tick & (state == SHIFT);
  assign data_in = shift & sd_s2;

  // word framing stage
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      ws_last      <= 1'b0;
      cur_ch       <= 1'b0;
      bit_cnt      <= '0;
      pend_start   <= 1'b0;
      left_fresh   <= 1'b0;
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
      sync_err     <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      sync_err     <= 1'b0;
      if (tick) ws_last <= ws_s2;
      case (state)
        IDLE: begin
          if (tick) state <= ARM;
        end
        ARM, WAIT: begin
          if (tick && ws_chg) begin
            state   <= SHIFT;
            cur_ch  <= ws_s2;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (bit_cnt_inc == WORD_CNT) begin
              // a ws edge on the LSB tick opens the next word right after capture
              state      <= CAPTURE;
              bit_cnt    <= bit_cnt_inc;
              pend_start <= ws_chg;
            end else if (ws_chg) begin
              sync_err <= 1'b1;
              bit_cnt  <= '0;
              cur_ch   <= ws_s2;
            end else begin
              bit_cnt <= bit_cnt_inc;
            end
          end
        end
        CAPTURE: begin
          if (cur_ch) begin
            right_sample <= sr_data;
            if (left_fresh) begin
              sample_valid <= 1'b1;
              left_fresh   <= 1'b0;
            end
          end else begin
            left_sample <= sr_data;
            left_fresh  <= 1'b1;
          end
          bit_cnt <= '0;
          if (pend_start) begin
            state      <= SHIFT;
            cur_ch     <= ~cur_ch;
            pend_start <= 1'b0;
          end else begin
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_rcvr_ctrl.sv
// Bench for i2s_rcvr_ctrl: builds I2S tick streams, predicts shifted bits, sample pairs and
// sync errors from the framing rules, and compares against the DUT and a modelled shift register.
module tb_i2s_rcvr_ctrl;

  logic        clk = 1'b0;
  logic        n_rst, sck, ws, sd;
  logic [15:0] sr_data;
  logic        shift, data_in, sample_valid, sync_err;
  logic [15:0] left_sample, right_sample;

  int n_tests = 0;
  int n_fail  = 0;

  bit          ws_a[$];
  bit          sd_a[$];
  bit          exp_bits[$];
  logic [31:0] exp_pairs[$];
  int          exp_err, exp_np, exp_shift;
  logic [15:0] m_left, m_right;
  bit          m_fresh;
  int          got_pairs, got_err, got_shift;
  logic        shift_prev = 1'b0;
  logic [31:0] pair;

  always #5 clk = ~clk;

  i2s_rcvr_ctrl #(.WORD_BITS(16)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .sck          (sck),
    .ws           (ws),
    .sd           (sd),
    .sr_data      (sr_data),
    .shift        (shift),
    .data_in      (data_in),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_valid (sample_valid),
    .sync_err     (sync_err)
  );

  // downstream serial-to-parallel register the controller drives
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) sr_data <= '0;
    else if (shift) sr_data <= {sr_data[14:0], data_in};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (n_rst === 1'b1) begin
      if (shift) begin
        got_shift++;
        check("shift_width", {31'b0, shift_prev}, 0);
        if (exp_bits.size() > 0) check("data_in", {31'b0, data_in}, {31'b0, exp_bits.pop_front()});
        else check("shift_unexpected", {31'b0, shift}, 0);
      end
      if (sample_valid) begin
        got_pairs++;
        if (exp_pairs.size() > 0) begin
          pair = exp_pairs.pop_front();
          check("pair_left", {16'b0, left_sample}, {16'b0, pair[31:16]});
          check("pair_right", {16'b0, right_sample}, {16'b0, pair[15:0]});
        end else begin
          check("sv_unexpected", {31'b0, sample_valid}, 0);
        end
      end
      if (sync_err) got_err++;
    end
    shift_prev = shift;
  end

  // Reference: first tick is the reference ws; every ws change opens a word whose next 16
  // ticks are its bits, a change before the 16th bit abandons it, a change on the 16th tick
  // opens the next word at once. A right word completes a pair only after a fresh left word.
  task automatic model();
    int n;
    int t, k, e;
    bit ch, abort;
    logic [15:0] val;
    n = ws_a.size();
    exp_bits.delete();
    exp_pairs.delete();
    exp_err = 0;
    exp_np  = 0;
    t = 1;
    while (t < n && ws_a[t] == ws_a[t-1]) t++;
    while (t < n) begin
      ch = ws_a[t];
      val = '0;
      abort = 1'b0;
      k = 1;
      while (k <= 16 && t + k < n) begin
        exp_bits.push_back(sd_a[t+k]);
        val = {val[14:0], sd_a[t+k]};
        if (k < 16 && ws_a[t+k] != ws_a[t+k-1]) begin
          abort = 1'b1;
          break;
        end
        k++;
      end
      if (abort) begin
        exp_err++;
        t = t + k;
      end else if (k <= 16) begin
        t = n;
      end else begin
        if (!ch) begin
          m_left  = val;
          m_fresh = 1'b1;
        end else begin
          m_right = val;
          if (m_fresh) begin
            exp_pairs.push_back({m_left, val});
            exp_np++;
            m_fresh = 1'b0;
          end
        end
        e = t + 16;
        if (ws_a[e] != ws_a[e-1]) t = e;
        else begin
          t = e + 1;
          while (t < n && ws_a[t] == ws_a[t-1]) t++;
        end
      end
    end
    exp_shift = exp_bits.size();
  endtask

  task automatic add_slot(input bit ch, input bit next_ch, input logic [15:0] word, input int len);
    for (int i = 0; i < len; i++) begin
      ws_a.push_back((i == len - 1) ? next_ch : ch);
      sd_a.push_back((i < 16) ? word[15-i] : 1'($urandom));
    end
  endtask

  task automatic add_prefix(input bit c0);
    ws_a.push_back(~c0); sd_a.push_back(1'($urandom));
    ws_a.push_back(~c0); sd_a.push_back(1'($urandom));
    ws_a.push_back(c0);  sd_a.push_back(1'($urandom));
  endtask

  task automatic apply_reset();
    sck = 1'b0; ws = 1'b0; sd = 1'b0;
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #3 n_rst = 1'b1;
    repeat (5) @(posedge clk);
    m_left = '0; m_right = '0; m_fresh = 1'b0;
  endtask

  task automatic drive();
    for (int t = 0; t < ws_a.size(); t++) begin
      sck = 1'b0; ws = ws_a[t]; sd = sd_a[t];
      #50 sck = 1'b1;
      #50;
    end
    sck = 1'b0;
  endtask

  task automatic run_stream(input string name, input bit do_rst);
    if (do_rst) apply_reset();
    model();
    got_pairs = 0; got_err = 0; got_shift = 0;
    drive();
    repeat (30) @(posedge clk);
    #1;
    check({name, "_pairs"}, got_pairs, exp_np);
    check({name, "_sync_err"}, got_err, exp_err);
    check({name, "_shifts"}, got_shift, exp_shift);
    check({name, "_bits_left"}, exp_bits.size(), 0);
    check({name, "_left"}, {16'b0, left_sample}, {16'b0, m_left});
    check({name, "_right"}, {16'b0, right_sample}, {16'b0, m_right});
    ws_a.delete();
    sd_a.delete();
    exp_bits.delete();
    exp_pairs.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_shift"}, {31'b0, shift}, 0);
    check({tag, "_data_in"}, {31'b0, data_in}, 0);
    check({tag, "_left"}, {16'b0, left_sample}, 0);
    check({tag, "_right"}, {16'b0, right_sample}, 0);
    check({tag, "_valid"}, {31'b0, sample_valid}, 0);
    check({tag, "_sync_err"}, {31'b0, sync_err}, 0);
  endtask

  initial begin
    logic [15:0] w0, w1;
    sck = 1'b0; ws = 1'b0; sd = 1'b0; n_rst = 1'b1;
    #2 n_rst = 1'b0;
    #1 check_zero("rst_init");
    apply_reset();
    check_zero("rst_release");

    // standard frames, 16 sck per channel
    add_prefix(1'b0);
    for (int f = 0; f < 5; f++) begin
      add_slot(1'b0, 1'b1, 16'hA5C3, 16);
      add_slot(1'b1, 1'b0, 16'h1234, 16);
    end
    run_stream("std", 1'b1);
    check("std_shift160", got_shift, 160);

    // 32 sck per channel, MSB aligned, random trailing bits
    add_prefix(1'b0);
    for (int f = 0; f < 3; f++) begin
      add_slot(1'b0, 1'b1, 16'h8001, 32);
      add_slot(1'b1, 1'b0, 16'h7FFE, 32);
    end
    run_stream("long", 1'b1);

    // left word cut short after 10 bits
    w0 = 16'($urandom); w1 = 16'($urandom);
    add_prefix(1'b0);
    add_slot(1'b0, 1'b1, w0, 16);
    add_slot(1'b1, 1'b0, w1, 16);
    for (int i = 0; i < 10; i++) begin
      ws_a.push_back(i == 9);
      sd_a.push_back(1'($urandom));
    end
    add_slot(1'b1, 1'b0, 16'($urandom), 16);
    run_stream("cut", 1'b1);
    check("cut_left_kept", {16'b0, left_sample}, {16'b0, w0});

    // right channel first
    add_prefix(1'b1);
    add_slot(1'b1, 1'b0, 16'($urandom), 16);
    add_slot(1'b0, 1'b1, 16'($urandom), 16);
    add_slot(1'b1, 1'b0, 16'($urandom), 16);
    run_stream("rfirst", 1'b1);

    // random words and random slot lengths
    for (int r = 0; r < 3; r++) begin
      add_prefix(1'b0);
      for (int f = 0; f < 4; f++) begin
        add_slot(1'b0, 1'b1, 16'($urandom), 16 + $urandom_range(0, 8));
        add_slot(1'b1, 1'b0, 16'($urandom), 16 + $urandom_range(0, 8));
      end
      run_stream("rand", 1'b1);
    end

    // random ws toggling, including words cut short
    begin
      bit cw;
      cw = 1'b0;
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 11) == 0) cw = ~cw;
        ws_a.push_back(cw);
        sd_a.push_back(1'($urandom));
      end
    end
    run_stream("chaos", 1'b1);

    // reset pulsed in the middle of a right word
    w0 = 16'($urandom) | 16'h0001;
    add_prefix(1'b0);
    add_slot(1'b0, 1'b1, w0, 16);
    add_slot(1'b1, 1'b1, 16'($urandom), 8);
    run_stream("rst_pre", 1'b1);
    #3 n_rst = 1'b0;
    #1 check_zero("rst_mid");
    repeat (3) @(posedge clk);
    #3 n_rst = 1'b1;
    repeat (5) @(posedge clk);
    m_left = '0; m_right = '0; m_fresh = 1'b0;
    add_prefix(1'b0);
    add_slot(1'b0, 1'b1, 16'($urandom), 16);
    add_slot(1'b1, 1'b0, 16'($urandom), 16);
    run_stream("rst_post", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
